reg_trace_matcher: RTL and testbench



---
 rtl/trace_regs_pkg.sv | 34 +++
 rtl/reg_trace_matcher_if.sv | 23 ++
 rtl/trace_hit_counter.sv | 40 ++++
 rtl/reg_trace_matcher.sv | 233 +++++++++++++++++++++++
 tb/tb_reg_trace_matcher.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_regs_pkg.sv
// Shared constants for the trace matcher register block: register map,
// identification values, STATUS bit positions and reset mask value.
package trace_regs_pkg;

    typedef enum logic [5:0] {
        REG_NAME                = 6'h00,
        REG_REV                 = 6'h01,
        REG_PATTERN_ENABLE      = 6'h02,
        REG_PATTERN_TRIG_ENABLE = 6'h03,
        REG_RULE_SEL            = 6'h04,
        REG_SHADOW_PATTERN      = 6'h05,
        REG_SHADOW_MASK         = 6'h06,
        REG_COMMIT              = 6'h07,
        REG_HIT_COUNT           = 6'h08,
        REG_STATUS              = 6'h09,
        REG_RESET_SYNC          = 6'h0A,
        REG_MATCHED_DATA        = 6'h0B
    } reg_addr_e;

    localparam logic [7:0]  REV               = 8'h02;
    // ASCII "TrcMatch"; byte 0 of the register is the leftmost character
    localparam logic [63:0] NAME              = 64'h5472_634D_6174_6368;
    localparam int          NAME_BYTES        = 8;
    localparam int          STATUS_SAT_BIT    = 0;
    localparam int          STATUS_SELERR_BIT = 1;
    localparam logic        DEFAULT_MASK_BIT  = 1'b1;

    function automatic logic [7:0] name_byte(input logic [2:0] idx);
        logic [63:0] shifted;
        shifted = NAME << {idx, 3'b000};
        return shifted[63:56];
    endfunction

endpackage

// File: rtl/reg_trace_matcher_if.sv
// USB register bus seen by the trace matcher register block.
interface reg_trace_matcher_if #(
    parameter int pBYTECNT_SIZE = 7
) ();
    logic [7:0]               reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               write_data;
    logic [7:0]               read_data;
    logic                     reg_read;
    logic                     reg_write;
    logic                     reg_addrvalid;
    logic                     selected;

    modport master (
        output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        input  read_data, selected
    );

    modport slave (
        input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        output read_data, selected
    );
endinterface

// File: rtl/trace_hit_counter.sv
// Saturating per-rule hit counter. A clear beats a same-cycle hit; sat
// is high while the count sits at all-ones.
module trace_hit_counter #(
    parameter int pCOUNT_WIDTH = 16
) (
    input  logic                    usb_clk,
    input  logic                    reset_n,
    input  logic                    hit,
    input  logic                    clear,
    output logic [pCOUNT_WIDTH-1:0] count,
    output logic                    sat
);
    localparam logic [pCOUNT_WIDTH-1:0] CNT_MAX = {pCOUNT_WIDTH{1'b1}};
    localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [pCOUNT_WIDTH-1:0] count_next_s;

    // next count: clear first, then a hit below saturation
    always_comb begin
        count_next_s = count;
        if (clear) begin
            count_next_s = {pCOUNT_WIDTH{1'b0}};
        end else if (hit && (count != CNT_MAX)) begin
            count_next_s = count + CNT_ONE;
        end else begin
            count_next_s = count;
        end
    end

    // count and saturation state
    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            count <= {pCOUNT_WIDTH{1'b0}};
            sat   <= 1'b0;
        end else begin
            count <= count_next_s;
            sat   <= (count_next_s == CNT_MAX);
        end
    end
endmodule

// File: rtl/reg_trace_matcher.sv
// Register block for the trace matcher: shadow-staged rule programming with
// atomic commit, live enables, saturating hit counters with snapshot readback.
module reg_trace_matcher
    import trace_regs_pkg::*;
#(
    parameter int         pBYTECNT_SIZE = 7,
    parameter int         pBUFFER_SIZE  = 64,
    parameter int         pMATCH_RULES  = 8,
    parameter int         pCOUNT_WIDTH  = 16,
    parameter logic [1:0] pSELECT       = 2'b01
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_n,
    reg_trace_matcher_if.slave                   bus,
    input  logic [pMATCH_RULES-1:0]              I_match_hit,
    input  logic [pBUFFER_SIZE-1:0]              I_matched_data,
    output logic [pMATCH_RULES-1:0]              O_pattern_enable,
    output logic [pMATCH_RULES-1:0]              O_pattern_trig_enable,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_trace_pattern,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_trace_mask,
    output logic                                 O_config_update,
    output logic                                 O_reset_sync
);
    localparam int         EN_BYTES  = (pMATCH_RULES + 7) / 8;
    localparam int         EN_PADW   = EN_BYTES * 8;
    localparam int         BUF_BYTES = pBUFFER_SIZE / 8;
    localparam int         CNT_BYTES = pCOUNT_WIDTH / 8;
    localparam logic [4:0] SEL_LIMIT = 5'(pMATCH_RULES);

    reg_addr_e                addr_s;
    int                       bi_s;
    logic                     wr_s;
    logic                     rd_s;
    logic                     wr_en_s;
    logic                     wr_ten_s;
    logic                     wr_sel_s;
    logic                     wr_spat_s;
    logic                     wr_smsk_s;
    logic                     commit_s;
    logic                     clr_cnt_s;
    logic                     wr_status_s;
    logic                     rs_wr_s;
    logic                     snap_latch_s;
    logic                     sel_valid_s;
    logic [pMATCH_RULES-1:0]  clear_vec_s;
    logic [pMATCH_RULES-1:0]  sat_s;
    logic [pCOUNT_WIDTH-1:0]  cnt_s [pMATCH_RULES];
    logic [pCOUNT_WIDTH-1:0]  sel_cnt_s;
    logic [EN_PADW-1:0]       en_cur_s;
    logic [EN_PADW-1:0]       ten_cur_s;
    logic [EN_PADW-1:0]       en_pad_s;
    logic [EN_PADW-1:0]       ten_pad_s;
    logic [7:0]               rd_mux_s;

    logic [3:0]               rule_sel_r;
    logic [pBUFFER_SIZE-1:0]  shadow_pattern_r;
    logic [pBUFFER_SIZE-1:0]  shadow_mask_r;
    logic [pCOUNT_WIDTH-1:0]  snap_r;
    logic [pMATCH_RULES-1:0]  sat_flag_r;
    logic [pMATCH_RULES-1:0]  sat_d_r;
    logic                     sel_err_r;
    logic                     rs_wr_d_r;
    logic [7:0]               read_data_r;

    assign bus.selected  = bus.reg_addrvalid & (bus.reg_address[7:6] == pSELECT);
    assign bus.read_data = read_data_r;

    assign addr_s       = reg_addr_e'(bus.reg_address[5:0]);
    assign bi_s         = int'(bus.reg_bytecnt);
    assign wr_s         = bus.selected & bus.reg_write;
    assign rd_s         = bus.selected & bus.reg_read;
    assign wr_en_s      = wr_s & (addr_s == REG_PATTERN_ENABLE) & (bi_s < EN_BYTES);
    assign wr_ten_s     = wr_s & (addr_s == REG_PATTERN_TRIG_ENABLE) & (bi_s < EN_BYTES);
    assign wr_sel_s     = wr_s & (addr_s == REG_RULE_SEL) & (bi_s == 0);
    assign wr_spat_s    = wr_s & (addr_s == REG_SHADOW_PATTERN) & (bi_s < BUF_BYTES);
    assign wr_smsk_s    = wr_s & (addr_s == REG_SHADOW_MASK) & (bi_s < BUF_BYTES);
    assign commit_s     = wr_s & (addr_s == REG_COMMIT);
    assign clr_cnt_s    = wr_s & (addr_s == REG_HIT_COUNT);
    assign wr_status_s  = wr_s & (addr_s == REG_STATUS) & (bi_s == 0);
    assign rs_wr_s      = wr_s & (addr_s == REG_RESET_SYNC);
    assign snap_latch_s = rd_s & (addr_s == REG_HIT_COUNT) & (bi_s == 0);
    assign sel_valid_s  = ({1'b0, rule_sel_r} < SEL_LIMIT);

    generate
        for (genvar gi = 0; gi < pMATCH_RULES; gi++) begin : g_cnt
            assign clear_vec_s[gi] = clr_cnt_s & sel_valid_s & (rule_sel_r == 4'(gi));

            trace_hit_counter #(
                .pCOUNT_WIDTH(pCOUNT_WIDTH)
            ) u_hit_counter (
                .usb_clk (usb_clk),
                .reset_n (reset_n),
                .hit     (I_match_hit[gi]),
                .clear   (clear_vec_s[gi]),
                .count   (cnt_s[gi]),
                .sat     (sat_s[gi])
            );
        end
    endgenerate

    // live count of the selected rule; zero when RULE_SEL is out of range
    always_comb begin
        sel_cnt_s = {pCOUNT_WIDTH{1'b0}};
        for (int i = 0; i < pMATCH_RULES; i++) begin
            sel_cnt_s = sel_cnt_s | (cnt_s[i] & {pCOUNT_WIDTH{rule_sel_r == 4'(i)}});
        end
    end

    // byte-padded views of the enables for bytewise update and readback
    always_comb begin
        en_cur_s  = EN_PADW'(O_pattern_enable);
        ten_cur_s = EN_PADW'(O_pattern_trig_enable);
        en_pad_s  = en_cur_s;
        ten_pad_s = ten_cur_s;
        if (wr_en_s) begin
            en_pad_s[bi_s*8 +: 8] = bus.write_data;
        end else begin
            en_pad_s = en_cur_s;
        end
        if (wr_ten_s) begin
            ten_pad_s[bi_s*8 +: 8] = bus.write_data;
        end else begin
            ten_pad_s = ten_cur_s;
        end
    end

    // readback multiplexer
    always_comb begin
        rd_mux_s = 8'h00;
        case (addr_s)
            REG_NAME:                rd_mux_s = (bi_s < NAME_BYTES) ? name_byte(bus.reg_bytecnt[2:0]) : 8'h00;
            REG_REV:                 rd_mux_s = (bi_s == 0) ? REV : 8'h00;
            REG_PATTERN_ENABLE:      rd_mux_s = (bi_s < EN_BYTES) ? en_cur_s[bi_s*8 +: 8] : 8'h00;
            REG_PATTERN_TRIG_ENABLE: rd_mux_s = (bi_s < EN_BYTES) ? ten_cur_s[bi_s*8 +: 8] : 8'h00;
            REG_RULE_SEL:            rd_mux_s = (bi_s == 0) ? {4'h0, rule_sel_r} : 8'h00;
            REG_SHADOW_PATTERN:      rd_mux_s = (bi_s < BUF_BYTES) ? shadow_pattern_r[bi_s*8 +: 8] : 8'h00;
            REG_SHADOW_MASK:         rd_mux_s = (bi_s < BUF_BYTES) ? shadow_mask_r[bi_s*8 +: 8] : 8'h00;
            REG_HIT_COUNT: begin
                if (bi_s == 0) begin
                    rd_mux_s = sel_cnt_s[7:0];
                end else if (bi_s < CNT_BYTES) begin
                    rd_mux_s = snap_r[bi_s*8 +: 8];
                end else begin
                    rd_mux_s = 8'h00;
                end
            end
            REG_STATUS: begin
                rd_mux_s = 8'h00;
                if (bi_s == 0) begin
                    rd_mux_s[STATUS_SAT_BIT]    = |sat_flag_r;
                    rd_mux_s[STATUS_SELERR_BIT] = sel_err_r;
                end else begin
                    rd_mux_s = 8'h00;
                end
            end
            REG_MATCHED_DATA:        rd_mux_s = (bi_s < BUF_BYTES) ? I_matched_data[bi_s*8 +: 8] : 8'h00;
            default:                 rd_mux_s = 8'h00;
        endcase
    end

    // configuration: enables, rule select, shadows and committed rules
    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            O_pattern_enable      <= {pMATCH_RULES{1'b0}};
            O_pattern_trig_enable <= {pMATCH_RULES{1'b0}};
            O_trace_pattern       <= {(pMATCH_RULES*pBUFFER_SIZE){1'b0}};
            O_trace_mask          <= {(pMATCH_RULES*pBUFFER_SIZE){DEFAULT_MASK_BIT}};
            O_config_update       <= 1'b0;
            rule_sel_r            <= 4'h0;
            shadow_pattern_r      <= {pBUFFER_SIZE{1'b0}};
            shadow_mask_r         <= {pBUFFER_SIZE{DEFAULT_MASK_BIT}};
        end else begin
            if (wr_en_s) begin
                O_pattern_enable <= en_pad_s[pMATCH_RULES-1:0];
            end
            if (wr_ten_s) begin
                O_pattern_trig_enable <= ten_pad_s[pMATCH_RULES-1:0];
            end
            if (wr_sel_s) begin
                rule_sel_r <= bus.write_data[3:0];
            end
            if (wr_spat_s) begin
                shadow_pattern_r[bi_s*8 +: 8] <= bus.write_data;
            end
            if (wr_smsk_s) begin
                shadow_mask_r[bi_s*8 +: 8] <= bus.write_data;
            end
            for (int i = 0; i < pMATCH_RULES; i++) begin
                if (commit_s && sel_valid_s && (rule_sel_r == 4'(i))) begin
                    O_trace_pattern[i*pBUFFER_SIZE +: pBUFFER_SIZE] <= shadow_pattern_r;
                    O_trace_mask[i*pBUFFER_SIZE +: pBUFFER_SIZE]    <= shadow_mask_r;
                end
            end
            O_config_update <= commit_s & sel_valid_s;
        end
    end

    // status flags, snapshot, resync edge detect and registered read data
    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            sat_flag_r   <= {pMATCH_RULES{1'b0}};
            sat_d_r      <= {pMATCH_RULES{1'b0}};
            sel_err_r    <= 1'b0;
            snap_r       <= {pCOUNT_WIDTH{1'b0}};
            rs_wr_d_r    <= 1'b0;
            O_reset_sync <= 1'b0;
            read_data_r  <= 8'h00;
        end else begin
            // a fresh saturation edge beats a same-cycle W1C
            for (int i = 0; i < pMATCH_RULES; i++) begin
                if (clear_vec_s[i]) begin
                    sat_flag_r[i] <= 1'b0;
                end else if (sat_s[i] && !sat_d_r[i]) begin
                    sat_flag_r[i] <= 1'b1;
                end else if (wr_status_s && bus.write_data[STATUS_SAT_BIT]) begin
                    sat_flag_r[i] <= 1'b0;
                end
            end
            sat_d_r <= sat_s;
            if ((commit_s || clr_cnt_s) && !sel_valid_s) begin
                sel_err_r <= 1'b1;
            end else if (wr_status_s && bus.write_data[STATUS_SELERR_BIT]) begin
                sel_err_r <= 1'b0;
            end
            if (snap_latch_s) begin
                snap_r <= sel_cnt_s;
            end
            rs_wr_d_r    <= rs_wr_s;
            O_reset_sync <= rs_wr_s & ~rs_wr_d_r;
            read_data_r  <= rd_s ? rd_mux_s : 8'h00;
        end
    end
endmodule

// File: tb/tb_reg_trace_matcher.sv
// Randomised self-checking bench for reg_trace_matcher against a byte-level
// behavioural model of the register map.
module tb_reg_trace_matcher;
    localparam int R    = 8;
    localparam int B    = 64;
    localparam int CW   = 16;
    localparam int BCW  = 7;
    localparam int CMAX = (1 << CW) - 1;

    logic           usb_clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [R-1:0]   hit_in  = '0;
    logic [B-1:0]   mdata   = '0;
    logic [R-1:0]   pen, pten;
    logic [R*B-1:0] tpat, tmsk;
    logic           cu, rsync;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_en, m_ten;
    logic [63:0] m_pat [R];
    logic [63:0] m_msk [R];
    logic [63:0] m_spat, m_smsk;
    int          m_sel, m_snap;
    int          m_cnt [R];
    bit          m_sat [R];
    bit          m_selerr, m_prev_rs;

    reg_trace_matcher_if #(.pBYTECNT_SIZE(BCW)) bus ();

    reg_trace_matcher #(
        .pBYTECNT_SIZE(BCW), .pBUFFER_SIZE(B), .pMATCH_RULES(R),
        .pCOUNT_WIDTH(CW), .pSELECT(2'b01)
    ) dut (
        .usb_clk               (usb_clk),
        .reset_n               (reset_n),
        .bus                   (bus),
        .I_match_hit           (hit_in),
        .I_matched_data        (mdata),
        .O_pattern_enable      (pen),
        .O_pattern_trig_enable (pten),
        .O_trace_pattern       (tpat),
        .O_trace_mask          (tmsk),
        .O_config_update       (cu),
        .O_reset_sync          (rsync)
    );

    always #5 usb_clk = ~usb_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_en = 8'h00; m_ten = 8'h00;
        m_spat = '0; m_smsk = '1;
        m_sel = 0; m_snap = 0; m_selerr = 1'b0; m_prev_rs = 1'b0;
        for (int i = 0; i < R; i++) begin
            m_pat[i] = '0; m_msk[i] = '1; m_cnt[i] = 0; m_sat[i] = 1'b0;
        end
    endfunction

    function automatic int live_cnt();
        return (m_sel < R) ? m_cnt[m_sel] : 0;
    endfunction

    function automatic logic [7:0] model_read(input int a, input int bc);
        string nm;
        bit any_sat;
        nm = "TrcMatch";
        any_sat = 1'b0;
        for (int i = 0; i < R; i++) any_sat |= m_sat[i];
        case (a)
            0:  return (bc < 8) ? 8'(nm[bc]) : 8'h00;
            1:  return (bc == 0) ? 8'h02 : 8'h00;
            2:  return (bc == 0) ? m_en : 8'h00;
            3:  return (bc == 0) ? m_ten : 8'h00;
            4:  return (bc == 0) ? 8'(m_sel) : 8'h00;
            5:  return (bc < 8) ? 8'(m_spat >> (8*bc)) : 8'h00;
            6:  return (bc < 8) ? 8'(m_smsk >> (8*bc)) : 8'h00;
            8:  return (bc == 0) ? 8'(live_cnt()) : ((bc < CW/8) ? 8'(m_snap >> (8*bc)) : 8'h00);
            9:  return (bc == 0) ? {6'b0, m_selerr, any_sat} : 8'h00;
            11: return (bc < 8) ? 8'(mdata >> (8*bc)) : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_step(input bit wr, input bit rd, input int a, input int bc,
                                       input logic [7:0] wd, input logic [R-1:0] h,
                                       output bit e_cu, output bit e_rs);
        bit clr [R];
        bit rs_now;
        e_cu = 1'b0; rs_now = 1'b0;
        for (int i = 0; i < R; i++) clr[i] = 1'b0;
        if (rd && a == 8 && bc == 0) m_snap = live_cnt();
        if (wr) begin
            case (a)
                2: if (bc == 0) m_en = wd;
                3: if (bc == 0) m_ten = wd;
                4: if (bc == 0) m_sel = int'(wd[3:0]);
                5: if (bc < 8) m_spat[bc*8 +: 8] = wd;
                6: if (bc < 8) m_smsk[bc*8 +: 8] = wd;
                7: if (m_sel < R) begin
                       m_pat[m_sel] = m_spat; m_msk[m_sel] = m_smsk; e_cu = 1'b1;
                   end else m_selerr = 1'b1;
                8: if (m_sel < R) begin
                       m_cnt[m_sel] = 0; m_sat[m_sel] = 1'b0; clr[m_sel] = 1'b1;
                   end else m_selerr = 1'b1;
                9: if (bc == 0) begin
                       if (wd[1]) m_selerr = 1'b0;
                       if (wd[0]) for (int i = 0; i < R; i++) m_sat[i] = 1'b0;
                   end
                10: rs_now = 1'b1;
                default: ;
            endcase
        end
        for (int i = 0; i < R; i++) begin
            if (h[i] && !clr[i] && m_cnt[i] < CMAX) begin
                m_cnt[i]++;
                if (m_cnt[i] == CMAX) m_sat[i] = 1'b1;
            end
        end
        e_rs = rs_now && !m_prev_rs;
        m_prev_rs = rs_now;
    endfunction

    task automatic bus_op(input bit wr, input bit rd, input int a, input int bc,
                          input logic [7:0] wd, input logic [R-1:0] h, input bit chk);
        logic [7:0] exp_rd;
        bit e_cu, e_rs;
        bus.reg_address   = {2'b01, 6'(a)};
        bus.reg_bytecnt   = 7'(bc);
        bus.write_data    = wd;
        bus.reg_write     = wr;
        bus.reg_read      = rd;
        bus.reg_addrvalid = wr | rd;
        hit_in            = h;
        exp_rd = model_read(a, bc);
        model_step(wr, rd, a, bc, wd, h, e_cu, e_rs);
        @(posedge usb_clk);
        #1;
        if (chk) begin
            if (rd) check_val($sformatf("read a=%0h bc=%0d", a, bc), 64'(bus.read_data), 64'(exp_rd));
            check_val("config_update", 64'(cu), 64'(e_cu));
            check_val("reset_sync", 64'(rsync), 64'(e_rs));
            check_val("pattern_enable", 64'(pen), 64'(m_en));
            check_val("trig_enable", 64'(pten), 64'(m_ten));
        end
    endtask

    task automatic wr_reg(input int a, input int bc, input logic [7:0] d);
        bus_op(1'b1, 1'b0, a, bc, d, '0, 1'b1);
    endtask

    task automatic rd_reg(input int a, input int bc);
        bus_op(1'b0, 1'b1, a, bc, 8'h00, '0, 1'b1);
    endtask

    task automatic idle();
        bus_op(1'b0, 1'b0, 0, 0, 8'h00, '0, 1'b1);
    endtask

    task automatic check_rules();
        for (int i = 0; i < R; i++) begin
            check_val($sformatf("pattern rule%0d", i), tpat[i*B +: B], m_pat[i]);
            check_val($sformatf("mask rule%0d", i), tmsk[i*B +: B], m_msk[i]);
        end
    endtask

    task automatic do_reset();
        bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
        hit_in = '0;
        reset_n = 1'b0;
        @(posedge usb_clk);
        #1;
        model_reset();
        reset_n = 1'b1;
        check_val("rst read_data", 64'(bus.read_data), 64'h0);
        check_val("rst config_update", 64'(cu), 64'h0);
        check_val("rst reset_sync", 64'(rsync), 64'h0);
        check_val("rst enable", 64'(pen), 64'h0);
        check_rules();
    endtask

    initial begin
        logic [63:0] pat5, msk5;
        pat5 = 64'h1122_3344_5566_7788;
        msk5 = 64'hFFFF_0000_FFFF_0000;
        bus.reg_address = 8'h00; bus.reg_bytecnt = '0; bus.write_data = 8'h00;
        bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
        @(posedge usb_clk);
        do_reset();

        // defaults and identification
        rd_reg(1, 0);
        check_val("rev", 64'(bus.read_data), 64'h02);
        check_val("mask rule3", tmsk[3*B +: B], 64'hFFFF_FFFF_FFFF_FFFF);
        rd_reg(2, 0);
        check_val("enable default", 64'(bus.read_data), 64'h00);
        for (int k = 0; k < 9; k++) rd_reg(0, k);
        rd_reg(1, 1);
        rd_reg(6'h20, 0);

        // address not selecting this block
        bus.reg_address = 8'hC1; bus.reg_addrvalid = 1'b1; bus.reg_read = 1'b1;
        #1;
        check_val("selected off", 64'(bus.selected), 64'h0);
        @(posedge usb_clk);
        #1;
        check_val("unselected read", 64'(bus.read_data), 64'h0);
        idle();

        // staged commit to rule 5
        wr_reg(4, 0, 8'h05);
        for (int k = 0; k < 8; k++) wr_reg(5, k, pat5[k*8 +: 8]);
        for (int k = 0; k < 8; k++) wr_reg(6, k, msk5[k*8 +: 8]);
        wr_reg(5, 8, 8'hAA);
        check_rules();
        wr_reg(7, 0, 8'h00);
        check_val("commit pulse", 64'(cu), 64'h1);
        check_val("rule5 pattern", tpat[5*B +: B], pat5);
        check_val("rule5 mask", tmsk[5*B +: B], msk5);
        check_rules();
        idle();
        check_val("commit pulse end", 64'(cu), 64'h0);
        wr_reg(5, 0, 8'h55);
        check_rules();
        rd_reg(5, 0);

        // out-of-range select
        wr_reg(4, 0, 8'h0C);
        wr_reg(7, 0, 8'h00);
        check_val("bad commit pulse", 64'(cu), 64'h0);
        check_rules();
        rd_reg(9, 0);
        check_val("status selerr", 64'(bus.read_data), 64'h02);
        wr_reg(9, 0, 8'h02);
        rd_reg(9, 0);
        check_val("status cleared", 64'(bus.read_data), 64'h00);
        wr_reg(8, 0, 8'h00);
        rd_reg(9, 0);
        wr_reg(9, 0, 8'h02);

        // live enables, including ignored out-of-width byte
        wr_reg(2, 0, 8'hA5);
        check_val("enable live", 64'(pen), 64'hA5);
        wr_reg(3, 0, 8'h3C);
        wr_reg(2, 1, 8'hFF);
        rd_reg(2, 0); rd_reg(2, 1); rd_reg(3, 0);

        // randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            int op, a, bc;
            op = int'($urandom_range(0, 2));
            a  = int'($urandom_range(0, 13));
            bc = int'($urandom_range(0, 9));
            mdata = {$urandom, $urandom};
            bus_op(op == 1, op == 2, a, bc, 8'($urandom), R'($urandom), 1'b1);
        end
        idle();
        check_rules();
        for (int r = 0; r < R; r++) begin
            wr_reg(4, 0, 8'(r));
            rd_reg(8, 0); rd_reg(8, 1); rd_reg(8, 2);
        end
        wr_reg(9, 0, 8'h03);

        // coherent snapshot on rule 1
        wr_reg(4, 0, 8'h01);
        wr_reg(8, 0, 8'h00);
        for (int n = 0; n < 255; n++) bus_op(1'b0, 1'b0, 0, 0, 8'h00, 8'h02, 1'b0);
        rd_reg(8, 0);
        check_val("snap byte0", 64'(bus.read_data), 64'hFF);
        bus_op(1'b0, 1'b0, 0, 0, 8'h00, 8'h02, 1'b1);
        rd_reg(8, 1);
        check_val("snap byte1", 64'(bus.read_data), 64'h00);
        bus_op(1'b0, 1'b1, 8, 0, 8'h00, 8'h02, 1'b1);
        rd_reg(8, 1);
        check_val("snap same-cycle hit", 64'(bus.read_data), 64'h01);

        // saturation and clear on rule 2
        wr_reg(4, 0, 8'h02);
        wr_reg(8, 0, 8'h00);
        for (int n = 0; n < 65540; n++) bus_op(1'b0, 1'b0, 0, 0, 8'h00, 8'h04, 1'b0);
        idle(); idle();
        rd_reg(8, 0);
        check_val("sat byte0", 64'(bus.read_data), 64'hFF);
        rd_reg(8, 1);
        check_val("sat byte1", 64'(bus.read_data), 64'hFF);
        rd_reg(9, 0);
        check_val("status sat", 64'(bus.read_data), 64'h01);
        bus_op(1'b1, 1'b0, 8, 0, 8'h00, 8'h04, 1'b1);
        rd_reg(8, 0);
        check_val("clear wins", 64'(bus.read_data), 64'h00);
        idle();
        rd_reg(9, 0);

        // resync pulse edge detection
        wr_reg(10, 0, 8'h01);
        check_val("resync first", 64'(rsync), 64'h1);
        wr_reg(10, 0, 8'h01);
        check_val("resync b2b", 64'(rsync), 64'h0);
        idle();
        wr_reg(10, 0, 8'h01);
        check_val("resync second", 64'(rsync), 64'h1);
        idle();

        // reset mid-sequence drops staged shadow data
        wr_reg(4, 0, 8'h00);
        wr_reg(5, 0, 8'h77);
        wr_reg(6, 0, 8'h00);
        do_reset();
        wr_reg(7, 0, 8'h00);
        check_val("post-reset pattern", tpat[0 +: B], 64'h0);
        check_val("post-reset mask", tmsk[0 +: B], 64'hFFFF_FFFF_FFFF_FFFF);
        check_rules();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
